// File: rtl/fixed_set_pkg.sv
// Package for fixed_set_tx: widths, default phase lengths, FSM state type
// and a small helper used to load the shared phase down-counter.
package fixed_set_pkg;

    localparam int DATA_W        = 8;
    localparam int CNT_W         = 4;
    localparam int SETUP_CYC_DEF = 2;
    localparam int PULSE_CYC_DEF = 4;
    localparam int HOLD_CYC_DEF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // The counter counts down to zero, so a phase of N cycles loads N-1.
    function automatic logic [CNT_W-1:0] cnt_load(input int cyc);
        return CNT_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/fixed_set_tx_if.sv
// Bus bundle for fixed_set_tx.
//   wr_en/wr_addr/wr_data : staging register writes (addr 0 = init, 1 = step)
//   commit                : request to publish the staged pair
//   busy/done             : transfer status back to the host
//   update_flag           : strobe to the downstream capture block
//   fixed_init/fixed_step : published values
// master = host/downstream side, slave = fixed_set_tx.
interface fixed_set_tx_if;

    logic                             wr_en;
    logic                             wr_addr;
    logic [fixed_set_pkg::DATA_W-1:0] wr_data;
    logic                             commit;
    logic                             busy;
    logic                             done;
    logic                             update_flag;
    logic [fixed_set_pkg::DATA_W-1:0] fixed_init;
    logic [fixed_set_pkg::DATA_W-1:0] fixed_step;

    modport master (
        output wr_en, wr_addr, wr_data, commit,
        input  busy, done, update_flag, fixed_init, fixed_step
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, commit,
        output busy, done, update_flag, fixed_init, fixed_step
    );

endinterface

// File: rtl/fixed_set_tx.sv
// fixed_set_tx: stages an init/step byte pair and publishes it to a
// downstream block with a setup / pulse / hold update_flag handshake.
//   clk     : sole clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : fixed_set_tx_if.slave (staging writes, commit, status, outputs)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for commit; published values held
// SETUP   | values published, update_flag low, SETUP_CYC cycles
// PULSE   | update_flag high, PULSE_CYC cycles
// HOLD    | update_flag low, values still held, HOLD_CYC cycles
module fixed_set_tx
    import fixed_set_pkg::*;
#(
    parameter int SETUP_CYC = SETUP_CYC_DEF,
    parameter int PULSE_CYC = PULSE_CYC_DEF,
    parameter int HOLD_CYC  = HOLD_CYC_DEF
) (
    input logic            clk,
    input logic            reset_n,
    fixed_set_tx_if.slave  bus
);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                pending;
    logic [DATA_W-1:0]   init_stage;
    logic [DATA_W-1:0]   step_stage;
    logic [DATA_W-1:0]   init_next;
    logic [DATA_W-1:0]   step_next;
    logic [DATA_W-1:0]   fixed_init_q;
    logic [DATA_W-1:0]   fixed_step_q;
    logic                update_flag_q;
    logic                done_q;

    // Staging contents including a write landing this cycle, so a snapshot
    // taken on the same edge sees the new byte.
    always_comb begin
        init_next = init_stage;
        step_next = step_stage;
        if (bus.wr_en) begin
            if (bus.wr_addr) begin
                step_next = bus.wr_data;
            end else begin
                init_next = bus.wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            pending       <= 1'b0;
            init_stage    <= '0;
            step_stage    <= '0;
            fixed_init_q  <= '0;
            fixed_step_q  <= '0;
            update_flag_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            init_stage <= init_next;
            step_stage <= step_next;
            done_q     <= 1'b0;

            // Any number of commits during a transfer collapse into one
            // request; the HOLD-exit branch below consumes it.
            if (bus.commit && (state != ST_IDLE)) begin
                pending <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.commit) begin
                        state        <= ST_SETUP;
                        cnt          <= cnt_load(SETUP_CYC);
                        fixed_init_q <= init_next;
                        fixed_step_q <= step_next;
                    end
                end
                ST_SETUP: begin
                    if (cnt == '0) begin
                        state         <= ST_PULSE;
                        cnt           <= cnt_load(PULSE_CYC);
                        update_flag_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (cnt == '0) begin
                        state         <= ST_HOLD;
                        cnt           <= cnt_load(HOLD_CYC);
                        update_flag_q <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        done_q <= 1'b1;
                        // A commit arriving on this very cycle counts too.
                        if (pending || bus.commit) begin
                            state        <= ST_SETUP;
                            cnt          <= cnt_load(SETUP_CYC);
                            fixed_init_q <= init_next;
                            fixed_step_q <= step_next;
                            pending      <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = (state != ST_IDLE);
    assign bus.done        = done_q;
    assign bus.update_flag = update_flag_q;
    assign bus.fixed_init  = fixed_init_q;
    assign bus.fixed_step  = fixed_step_q;

endmodule

// File: tb/tb_fixed_set_tx.sv
// Self-checking bench for fixed_set_tx: a directed vector table, hand-written
// corner sequences and random traffic, all checked cycle by cycle against a
// transfer-level reference model. A second instance with minimum phase
// lengths runs on the same stimulus, and a 2-flop synchroniser capture model
// confirms each transfer is captured exactly once with the right values.
module tb_fixed_set_tx;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_en;
    logic       wr_addr;
    logic [7:0] wr_data;
    logic       commit;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fixed_set_tx_if if0 ();
    fixed_set_tx_if if1 ();

    assign if0.wr_en = wr_en;  assign if0.wr_addr = wr_addr;
    assign if0.wr_data = wr_data;  assign if0.commit = commit;
    assign if1.wr_en = wr_en;  assign if1.wr_addr = wr_addr;
    assign if1.wr_data = wr_data;  assign if1.commit = commit;

    fixed_set_tx #(.SETUP_CYC(2), .PULSE_CYC(4), .HOLD_CYC(4)) dut (
        .clk(clk), .reset_n(reset_n), .bus(if0.slave));

    fixed_set_tx #(.SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)) dut_min (
        .clk(clk), .reset_n(reset_n), .bus(if1.slave));

    // Reference model: a transfer is "active" for S+P+H cycles counted by t,
    // update_flag is expected for t in [S, S+P).
    int         ps[2] = '{2, 1};
    int         pp[2] = '{4, 2};
    int         ph[2] = '{4, 1};
    bit         m_act[2];
    int         m_t[2];
    bit         m_pend[2];
    bit         m_done[2];
    logic [7:0] m_si[2], m_ss[2], m_fi[2], m_fs[2], m_lfi[2], m_lfs[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_update(input int k);
        int         tot;
        logic [7:0] ni, ns;
        tot = ps[k] + pp[k] + ph[k];
        if (!reset_n) begin
            m_act[k] = 0; m_t[k] = 0; m_pend[k] = 0; m_done[k] = 0;
            m_si[k] = 0; m_ss[k] = 0; m_fi[k] = 0; m_fs[k] = 0;
            return;
        end
        ni = (wr_en && !wr_addr) ? wr_data : m_si[k];
        ns = (wr_en &&  wr_addr) ? wr_data : m_ss[k];
        m_done[k] = 0;
        if (!m_act[k]) begin
            if (commit) begin
                m_act[k] = 1; m_t[k] = 0; m_fi[k] = ni; m_fs[k] = ns;
            end
        end else if (m_t[k] == tot - 1) begin
            m_done[k] = 1;
            m_lfi[k]  = m_fi[k];
            m_lfs[k]  = m_fs[k];
            if (m_pend[k] || commit) begin
                m_t[k] = 0; m_fi[k] = ni; m_fs[k] = ns; m_pend[k] = 0;
            end else begin
                m_act[k] = 0;
            end
        end else begin
            m_t[k]++;
            if (commit) m_pend[k] = 1;
        end
        m_si[k] = ni;
        m_ss[k] = ns;
    endtask

    task automatic get_outs(input int k, output logic b, output logic f, output logic d,
                            output logic [7:0] fi, output logic [7:0] fs);
        if (k == 0) begin
            b = if0.busy; f = if0.update_flag; d = if0.done; fi = if0.fixed_init; fs = if0.fixed_step;
        end else begin
            b = if1.busy; f = if1.update_flag; d = if1.done; fi = if1.fixed_init; fs = if1.fixed_step;
        end
    endtask

    task automatic step();
        logic       b, f, d, ef;
        logic [7:0] fi, fs;
        @(posedge clk);
        model_update(0);
        model_update(1);
        #1;
        for (int k = 0; k < 2; k++) begin
            get_outs(k, b, f, d, fi, fs);
            ef = m_act[k] && (m_t[k] >= ps[k]) && (m_t[k] < ps[k] + pp[k]);
            chk($sformatf("model_busy%0d", k), b, m_act[k]);
            chk($sformatf("model_flag%0d", k), f, ef);
            chk($sformatf("model_done%0d", k), d, m_done[k]);
            chk($sformatf("model_init%0d", k), fi, m_fi[k]);
            chk($sformatf("model_step%0d", k), fs, m_fs[k]);
        end
    endtask

    task automatic drive(input bit r, input bit we, input bit a, input logic [7:0] dat, input bit c);
        reset_n = r; wr_en = we; wr_addr = a; wr_data = dat; commit = c;
        step();
    endtask

    // Downstream capture model: update_flag through two flops, capture on the
    // rising edge of the synchronised flag.
    logic       s1[2] = '{0, 0}, s2[2] = '{0, 0}, s3[2] = '{0, 0};
    int         capn[2] = '{0, 0};
    logic [7:0] capi[2], caps[2];

    always @(negedge clk) begin
        logic       b, f, d;
        logic [7:0] fi, fs;
        for (int k = 0; k < 2; k++) begin
            get_outs(k, b, f, d, fi, fs);
            if (b !== 1'b1 && d !== 1'b1) begin
                s1[k] = 0; s2[k] = 0; s3[k] = 0; capn[k] = 0;
            end else begin
                s3[k] = s2[k]; s2[k] = s1[k]; s1[k] = f;
                if (s2[k] && !s3[k]) begin
                    capn[k]++; capi[k] = fi; caps[k] = fs;
                end
                if (d === 1'b1) begin
                    chk($sformatf("cap_count%0d", k), capn[k], 1);
                    chk($sformatf("cap_init%0d", k), capi[k], m_lfi[k]);
                    chk($sformatf("cap_step%0d", k), caps[k], m_lfs[k]);
                    capn[k] = 0;
                end
            end
        end
    end

    typedef struct {
        bit         r, we, a;
        logic [7:0] d;
        bit         c;
        bit         eb, ef, ed;
        logic [7:0] ei, es;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int dn[$];
        int r;
        reset_n = 0; wr_en = 0; wr_addr = 0; wr_data = 0; commit = 0;

        // Directed table: each row is one cycle of inputs and the outputs
        // expected in the following cycle. Commit row is cycle 0.
        tbl.push_back('{0, 1, 0, 8'hFF, 1, 0, 0, 0, 8'h00, 8'h00});
        tbl.push_back('{1, 1, 0, 8'h12, 0, 0, 0, 0, 8'h00, 8'h00});
        tbl.push_back('{1, 1, 1, 8'h34, 0, 0, 0, 0, 8'h00, 8'h00});
        tbl.push_back('{1, 0, 0, 8'h00, 1, 1, 0, 0, 8'h12, 8'h34}); // -> cyc 1
        tbl.push_back('{1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h12, 8'h34}); // -> cyc 2
        tbl.push_back('{1, 0, 0, 8'h00, 0, 1, 1, 0, 8'h12, 8'h34}); // -> cyc 3
        tbl.push_back('{1, 0, 0, 8'h00, 0, 1, 1, 0, 8'h12, 8'h34});
        tbl.push_back('{1, 0, 0, 8'h00, 0, 1, 1, 0, 8'h12, 8'h34});
        tbl.push_back('{1, 0, 0, 8'h00, 0, 1, 1, 0, 8'h12, 8'h34}); // -> cyc 6
        tbl.push_back('{1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h12, 8'h34}); // -> cyc 7
        tbl.push_back('{1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h12, 8'h34});
        tbl.push_back('{1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h12, 8'h34});
        tbl.push_back('{1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h12, 8'h34}); // -> cyc 10
        tbl.push_back('{1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h12, 8'h34}); // -> cyc 11
        tbl.push_back('{1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h12, 8'h34}); // -> cyc 12

        drive(0, 0, 0, 8'h00, 0);
        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].c);
            chk($sformatf("tbl_busy[%0d]", i), if0.busy, tbl[i].eb);
            chk($sformatf("tbl_flag[%0d]", i), if0.update_flag, tbl[i].ef);
            chk($sformatf("tbl_done[%0d]", i), if0.done, tbl[i].ed);
            chk($sformatf("tbl_init[%0d]", i), if0.fixed_init, tbl[i].ei);
            chk($sformatf("tbl_step[%0d]", i), if0.fixed_step, tbl[i].es);
        end
        for (int i = 0; i < 4; i++) drive(1, 0, 0, 8'h00, 0);

        // Staging write mid-transfer must not disturb published value.
        drive(1, 0, 0, 8'h00, 1);
        for (int c = 1; c <= 10; c++) begin
            drive(1, c == 4, 0, 8'h55, 0);
            chk("hold_init", if0.fixed_init, 8'h12);
        end
        drive(1, 0, 0, 8'h00, 1);
        chk("second_commit_init", if0.fixed_init, 8'h55);
        for (int i = 0; i < 14; i++) drive(1, 0, 0, 8'h00, 0);

        // Three commits during PULSE collapse into one extra transfer.
        for (int c = 0; c <= 30; c++) begin
            drive(1, 0, 0, 8'h00, (c == 0) || (c == 3) || (c == 4) || (c == 5));
            if (if0.done) dn.push_back(c + 1);
            if (c + 1 == 11) chk("reenter_busy", if0.busy, 1);
        end
        chk("pend_done_count", dn.size(), 2);
        if (dn.size() == 2) begin
            chk("pend_done0_cyc", dn[0], 11);
            // Re-entry at cycle 11 plus SETUP+PULSE+HOLD of the second transfer.
            chk("pend_done1_cyc", dn[1], 21);
        end

        // Write bypass on the snapshot edge.
        drive(1, 1, 1, 8'hA5, 1);
        chk("bypass_step", if0.fixed_step, 8'hA5);
        chk("bypass_init", if0.fixed_init, 8'h55);
        for (int i = 0; i < 12; i++) drive(1, 0, 0, 8'h00, 0);

        // Reset during PULSE with a pending commit.
        drive(1, 0, 0, 8'h00, 1);
        drive(1, 0, 0, 8'h00, 0);
        drive(1, 0, 0, 8'h00, 0);
        drive(1, 0, 0, 8'h00, 1);
        chk("pre_rst_flag", if0.update_flag, 1);
        drive(0, 0, 0, 8'h00, 0);
        chk("rst_busy", if0.busy, 0);
        chk("rst_flag", if0.update_flag, 0);
        chk("rst_done", if0.done, 0);
        chk("rst_init", if0.fixed_init, 8'h00);
        chk("rst_step", if0.fixed_step, 8'h00);
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 8'h00, 0);
            chk("post_rst_busy", if0.busy, 0);
            chk("post_rst_done", if0.done, 0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 299);
            drive(r != 0, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                  8'($urandom), $urandom_range(0, 5) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
